add_share_arb: RTL and testbench
================================

// Module: add_share_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one registered adder among NUM_REQ requesters.
//  Grants one requester at a time and captures its operand pair.
//  Issues the pair to the adder, waits out the adder latency, then returns sum + requester id.
//  Sits between requester blocks and the single adder datapath; one transaction in flight.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  DW       2  operand/sum width in bits (matches adder datapath width)
//  LAT      1  adder register latency in cycles (1..4)
//  IDW      2  requester id width, = clog2(NUM_REQ)
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           asynchronous reset, active-high
//  req_valid   in   NUM_REQ     per-requester operand pair valid
//  req_ready   out  NUM_REQ     per-requester accept (one-hot or zero)
//  req_a       in   NUM_REQ*DW  operand a, requester i at [i*DW +: DW]
//  req_b       in   NUM_REQ*DW  operand b, same packing
//  rsp_valid   out  1           result valid
//  rsp_ready   in   1           result consumer ready
//  rsp_id      out  IDW         requester index owning result
//  rsp_sum     out  DW          a+b (mod 2^DW, or saturated, see CONFIGURATION)
//  rsp_carry   out  1           carry-out of full DW-bit add
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : grant g = first i with req_valid[i], searching from pointer upward, wrapping at NUM_REQ.
//          req_ready[g]=1 combinationally this cycle; handshake = req_valid&req_ready.
//          On handshake latch a/b/g, go ISSUE. No req_valid: stay IDLE, req_ready=0.
//   ISSUE: drive latched operands into adder for 1 cycle; load wait counter = LAT-1; go WAIT.
//   WAIT : decrement counter; at 0 capture adder {carry,sum} into rsp regs, go RESP.
//   RESP : rsp_valid=1; rsp_id/sum/carry stable while rsp_valid&!rsp_ready.
//          On rsp_ready: rsp_valid deasserts next cycle; pointer=(g+1) mod NUM_REQ; go IDLE.
//  req_ready is 0 in all states except IDLE; never more than one bit set.
//  Request-to-response latency: handshake at cycle T -> rsp_valid at T+LAT+2.
//  Max throughput with rsp_ready=1: one result per LAT+3 cycles.
//  Arithmetic: {rsp_carry,raw} = a + b at DW+1 bits, unsigned.
//  Pointer wrap: g=NUM_REQ-1 -> pointer 0.
//  Requester deasserting req_valid while not granted: no effect, no grant recorded.
//  All req_valid high continuously: grants strictly rotate 0,1,..,NUM_REQ-1,0.
//  Async rst mid-transaction: in-flight op discarded, no response, FSM IDLE, pointer 0.
//  Adder is held in reset by rst; its output is ignored outside WAIT.
// CONFIGURATION
//  ADD_SHARE_ARB_SAT_EN defined:
//   rsp_sum = carry ? {DW{1'b1}} : raw (saturating).
//   rsp_carry still reports the overflow.
//  Not defined: rsp_sum = raw (wrap mod 2^DW).
//   No saturation logic is present.
// STRUCTURE
//  Package add_share_pkg:
//   state enum IDLE/ISSUE/WAIT/RESP (2-bit encoding).
//   Default DW/NUM_REQ/LAT constants.
//   Function rr_pick(valid, ptr) returning the grant index.
//  Sub-module add_share_pipe:
//   LAT-stage registered adder, DW-bit in, DW+1-bit out, reset to 0 by rst.
//  Top holds FSM, rr pointer, operand/id latches, wait counter, response regs.
// TESTING
//  1. Reset: rst high 3 cycles, all req_valid=1 -> req_ready=0, rsp_valid=0, outputs 0.
//  2. Single op: req1 a=2'b01 b=2'b01, rsp_ready=1 -> rsp_id=1, sum=2'b10, carry=0, at T+LAT+2.
//  3. Overflow: a=2'b11 b=2'b10 -> carry=1, sum=2'b01; with _SAT_EN sum=2'b11.
//  4. Fairness: all 4 req_valid held high, 8 ops -> grant ids 0,1,2,3,0,1,2,3.
//  5. Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0, then 1 accept.
//  6. Mid-op reset: assert rst in WAIT -> no rsp_valid ever for that op; next grant starts at id 0.

Source files
------------

// File: rtl/add_share_pkg.sv
// add_share_pkg: shared types, default sizes and round-robin pick for add_share_arb.
package add_share_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DW = 2;
    localparam int DEF_LAT = 1;
    // First set bit of valid at or above ptr, wrapping at n; callers size-limit to 8 requesters.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input logic [3:0] n);
        logic [2:0] pick;
        logic [3:0] idx;
        logic found;
        pick = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) idx = idx - n;
            if (4'(k) < n && !found && valid[idx[2:0]]) begin
                pick = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/add_share_pipe.sv
// add_share_pipe: LAT-stage registered adder, DW-bit operands, DW+1-bit result.
module add_share_pipe #(
    parameter int DW  = 2,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW:0]   sum
);
    logic [DW:0] stage [LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= {1'b0, a} + {1'b0, b};
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end
    assign sum = stage[LAT-1];
endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: round-robin sequencer sharing one registered adder among NUM_REQ requesters.
// Define ADD_SHARE_ARB_SAT_EN to saturate rsp_sum on overflow instead of wrapping.
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW,
    parameter int LAT     = DEF_LAT,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_sum,
    output logic                  rsp_carry
);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
    state_t state, state_nx;
    logic [IDW-1:0] ptr, g, g_q;
    logic [DW-1:0] a_q, b_q, add_a, add_b, res_sum;
    logic [DW:0] add_out;
    logic [CW-1:0] cnt;
    logic any_req;

    assign any_req = |req_valid;
    assign g = IDW'(rr_pick(8'(req_valid), 3'(ptr), 4'(NUM_REQ)));

    add_share_pipe #(.DW(DW), .LAT(LAT)) u_pipe (
        .clk (clk),
        .rst (rst),
        .a   (add_a),
        .b   (add_b),
        .sum (add_out)
    );

`ifdef ADD_SHARE_ARB_SAT_EN
    assign res_sum = add_out[DW] ? '1 : add_out[DW-1:0];
`else
    assign res_sum = add_out[DW-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = cnt == '0 ? RESP : WAIT;
            default: state_nx = rsp_ready ? IDLE : RESP;
        endcase
    end

    // rst gates the grant so no requester sees ready while the block is held in reset
    always_comb begin
        req_ready = (state == IDLE && any_req && !rst) ? NUM_REQ'(1) << g : '0;
        rsp_valid = state == RESP;
        add_a     = state == ISSUE ? a_q : '0;
        add_b     = state == ISSUE ? b_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            g_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                a_q <= req_a[g*DW +: DW];
                b_q <= req_b[g*DW +: DW];
                g_q <= g;
            end
            if (state == ISSUE) cnt <= CW'(LAT - 1);
            else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0) begin
                rsp_carry <= add_out[DW];
                rsp_sum   <= res_sum;
                rsp_id    <= g_q;
            end
            if (state == RESP && rsp_ready) ptr <= g_q == IDW'(NUM_REQ - 1) ? '0 : g_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb: randomized scoreboard bench for add_share_arb against a transaction-level model.
module tb_add_share_arb;
    localparam int N = 4;
    localparam int DW = 2;
    localparam int LAT = 1;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '1;
    logic [N-1:0] req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [IDW-1:0] rsp_id;
    logic [DW-1:0] rsp_sum;
    logic rsp_carry;

    add_share_arb #(.NUM_REQ(N), .DW(DW), .LAT(LAT), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int sum;
        int carry;
        int due;
    } exp_t;

    exp_t q[$];
    int grants[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accepted = 0;
    int m_ptr = 0;
    bit m_idle = 1;
    bit held = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic exp_t model(input int id, input int a, input int b, input int due);
        exp_t e;
        int s;
        s = a + b;
        e.id = id;
        e.carry = s >> DW;
        e.sum = s % (1 << DW);
`ifdef ADD_SHARE_ARB_SAT_EN
        if (e.carry != 0) e.sum = (1 << DW) - 1;
`endif
        e.due = due;
        return e;
    endfunction

    // Monitor and scoreboard: grant prediction, response comparison, latency and stability
    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        exp_t e;
        if (rst) begin
            m_idle = 1;
            m_ptr = 0;
            held = 0;
            q.delete();
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
            chk("rst_rsp_sum", int'(rsp_sum), 0);
            chk("rst_rsp_carry", int'(rsp_carry), 0);
        end else begin
            exp_rdy = '0;
            g = -1;
            if (m_idle && req_valid != 0) begin
                g = pick(req_valid, m_ptr);
                exp_rdy[g] = 1'b1;
            end
            chk("req_ready", int'(req_ready), int'(exp_rdy));
            if (g >= 0) begin
                q.push_back(model(g, int'(req_a[g*DW +: DW]), int'(req_b[g*DW +: DW]), cyc + LAT + 2));
                grants.push_back(g);
                m_idle = 0;
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    fail("rsp_spurious");
                end else begin
                    e = q[0];
                    chk("rsp_id", int'(rsp_id), e.id);
                    chk("rsp_sum", int'(rsp_sum), e.sum);
                    chk("rsp_carry", int'(rsp_carry), e.carry);
                    if (!held) chk("rsp_latency", cyc, e.due);
                    held = !rsp_ready;
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        m_ptr = (e.id + 1) % N;
                        m_idle = 1;
                        accepted++;
                    end
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                fail("rsp_timeout");
                void'(q.pop_front());
                m_idle = 1;
                held = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input int a, input int b);
        bit ok = 0;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*DW +: DW] = DW'(a);
        req_b[id*DW +: DW] = DW'(b);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = |(req_ready & req_valid);
        end
        if (!ok) fail("issue_handshake");
        step();
        req_valid = '0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            step();
            ok = q.size() == 0 && !rsp_valid;
        end
        if (!ok) fail("wait_idle");
    endtask

    initial begin
        int base;
        bit ok;
        repeat (3) step();
        rst = 1'b0;
        req_valid = '0;
        step();

        // Fairness: every requester valid, grants must rotate 0..3 twice
        base = grants.size();
        req_valid = '1;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            step();
            ok = grants.size() >= base + 8;
        end
        req_valid = '0;
        if (!ok) fail("fairness_ops");
        else for (int k = 0; k < 8; k++) chk("fairness_id", grants[base + k], k % N);
        wait_idle();

        issue(1, 1, 1);
        wait_idle();
        issue(2, 3, 2);
        wait_idle();

        // Backpressure: response held for 5 cycles while others request
        rsp_ready = 1'b0;
        issue(0, 3, 3);
        req_valid = '1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            step();
            ok = rsp_valid;
        end
        if (!ok) fail("bp_rsp_valid");
        repeat (5) step();
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        wait_idle();

        // Reset in WAIT discards the op; next grant with all valid must be 0
        issue(2, 1, 2);
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        base = grants.size();
        req_valid = '1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            step();
            ok = grants.size() > base;
        end
        req_valid = '0;
        if (!ok) fail("post_reset_grant");
        else chk("post_reset_grant", grants[base], 0);
        wait_idle();

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            req_valid = N'($urandom_range(0, 15));
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("random_ops_done", int'(accepted > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
